// File: rtl/dcache_lru_if.sv
// dcache_lru_if: CPU-side and memory-side signal bundle for dcache_lru.
//   CPU side : addr, rd_req, wr_req, wr_data -> cache; rd_data, miss <- cache
//   Mem side : mem_addr, mem_rd_req, mem_wr_req, mem_wr_line <- cache;
//              mem_rd_line, mem_gnt -> cache
// slave modport is the cache; master modport is the CPU/memory environment.
interface dcache_lru_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 10
);
  localparam int LINE_BITS = 32 << LINE_ADDR_LEN;

  logic [31:0]                          addr;
  logic                                 rd_req;
  logic                                 wr_req;
  logic [31:0]                          wr_data;
  logic [31:0]                          rd_data;
  logic                                 miss;
  logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr;
  logic                                 mem_rd_req;
  logic                                 mem_wr_req;
  logic [LINE_BITS-1:0]                 mem_wr_line;
  logic [LINE_BITS-1:0]                 mem_rd_line;
  logic                                 mem_gnt;

  modport slave (
    input  addr, rd_req, wr_req, wr_data, mem_rd_line, mem_gnt,
    output rd_data, miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line
  );

  modport master (
    output addr, rd_req, wr_req, wr_data, mem_rd_line, mem_gnt,
    input  rd_data, miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line
  );
endinterface

// File: rtl/dcache_lru.sv
// dcache_lru: set-associative write-back, write-allocate data cache with
// age-counter LRU replacement.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dcache_lru_if.slave (CPU request/response and line-level
//              memory fetch/writeback handshake)
// Parameters: LINE_ADDR_LEN (log2 words/line), SET_ADDR_LEN (log2 sets),
//             TAG_ADDR_LEN (tag width), WAY_CNT (ways, power of two >= 2).
module dcache_lru #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 10,
  parameter int WAY_CNT       = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_lru_if.slave bus
);
  localparam int WORDS     = 1 << LINE_ADDR_LEN;
  localparam int SETS      = 1 << SET_ADDR_LEN;
  localparam int LINE_BITS = 32 * WORDS;
  localparam int WAY_W     = $clog2(WAY_CNT);
  localparam int SET_LSB   = LINE_ADDR_LEN + 2;
  localparam int TAG_LSB   = SET_LSB + SET_ADDR_LEN;
  localparam int ADDR_TOP  = TAG_LSB + TAG_ADDR_LEN;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SWAP_OUT   = 2'd1;
  localparam logic [1:0] SWAP_IN    = 2'd2;
  localparam logic [1:0] SWAP_IN_OK = 2'd3;

  // Address decode
  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [LINE_ADDR_LEN+4:0] word_lsb;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_ADDR_LEN-1:0]  tag_in;
  logic                     unused_addr_bits;

  assign word_idx = bus.addr[SET_LSB-1:2];
  assign word_lsb = {word_idx, 5'b0};
  assign set_idx  = bus.addr[TAG_LSB-1:SET_LSB];
  assign tag_in   = bus.addr[ADDR_TOP-1:TAG_LSB];
  assign unused_addr_bits = ^{bus.addr[1:0], bus.addr >> ADDR_TOP};

  // State
  logic [1:0]                     state_q, state_d;
  logic                           valid_q [SETS][WAY_CNT];
  logic                           valid_d [SETS][WAY_CNT];
  logic                           dirty_q [SETS][WAY_CNT];
  logic                           dirty_d [SETS][WAY_CNT];
  logic [WAY_W-1:0]               age_q   [SETS][WAY_CNT];
  logic [WAY_W-1:0]               age_d   [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0]        tag_q   [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0]        tag_d   [SETS][WAY_CNT];
  logic [LINE_BITS-1:0]           data_q  [SETS][WAY_CNT];
  logic [LINE_BITS-1:0]           data_d  [SETS][WAY_CNT];
  logic [LINE_BITS-1:0]           fill_q, fill_d;
  logic [WAY_W-1:0]               victim_q, victim_d;
  logic [SET_ADDR_LEN-1:0]        req_set_q, req_set_d;
  logic [TAG_ADDR_LEN-1:0]        req_tag_q, req_tag_d;
  logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]                    rd_data_q, rd_data_d;

  // Lookup and victim choice for the addressed set
  logic             req;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             vic_free;
  logic [WAY_W-1:0] vic_way;

  assign req = bus.rd_req | bus.wr_req;

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    vic_free = 1'b0;
    vic_way  = '0;
    for (int unsigned w = 0; w < WAY_CNT; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vic_free && !valid_q[set_idx][w]) begin
        vic_free = 1'b1;
        vic_way  = WAY_W'(w);
      end
    end
    if (!vic_free) begin
      for (int unsigned w = 0; w < WAY_CNT; w++) begin
        if (age_q[set_idx][w] == WAY_W'(WAY_CNT - 1)) vic_way = WAY_W'(w);
      end
    end
  end

  // Next-state logic
  logic                    lru_en;
  logic [SET_ADDR_LEN-1:0] lru_set;
  logic [WAY_W-1:0]        lru_way;
  logic [WAY_W-1:0]        lru_old;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    age_d     = age_q;
    tag_d     = tag_q;
    data_d    = data_q;
    fill_d    = fill_q;
    victim_d  = victim_q;
    req_set_d = req_set_q;
    req_tag_d = req_tag_q;
    mem_addr_d = mem_addr_q;
    rd_data_d = rd_data_q;
    lru_en    = 1'b0;
    lru_set   = set_idx;
    lru_way   = hit_way;
    lru_old   = age_q[set_idx][hit_way];

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_any) begin
            lru_en = 1'b1;
            // A simultaneous read+write is serviced as a write only.
            if (bus.wr_req) begin
              data_d[set_idx][hit_way][word_lsb +: 32] = bus.wr_data;
              dirty_d[set_idx][hit_way] = 1'b1;
            end else begin
              rd_data_d = data_q[set_idx][hit_way][word_lsb +: 32];
            end
          end else begin
            victim_d  = vic_way;
            req_set_d = set_idx;
            req_tag_d = tag_in;
            if (valid_q[set_idx][vic_way] && dirty_q[set_idx][vic_way]) begin
              state_d    = SWAP_OUT;
              mem_addr_d = {tag_q[set_idx][vic_way], set_idx};
            end else begin
              state_d    = SWAP_IN;
              mem_addr_d = {tag_in, set_idx};
            end
          end
        end
      end
      SWAP_OUT: begin
        if (bus.mem_gnt) begin
          state_d    = SWAP_IN;
          mem_addr_d = {req_tag_q, req_set_q};
        end
      end
      SWAP_IN: begin
        if (bus.mem_gnt) begin
          fill_d  = bus.mem_rd_line;
          state_d = SWAP_IN_OK;
        end
      end
      SWAP_IN_OK: begin
        valid_d[req_set_q][victim_q] = 1'b1;
        dirty_d[req_set_q][victim_q] = 1'b0;
        tag_d[req_set_q][victim_q]   = req_tag_q;
        data_d[req_set_q][victim_q]  = fill_q;
        // The installed way is treated as the oldest, so an install into a
        // previously invalid way still ages every other way; this keeps the
        // valid ways of a set at distinct ages 0..k-1 and makes the age
        // WAY_CNT-1 way well defined once the set is full.
        lru_en  = 1'b1;
        lru_set = req_set_q;
        lru_way = victim_q;
        lru_old = WAY_W'(WAY_CNT - 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (lru_en) begin
      for (int unsigned w = 0; w < WAY_CNT; w++) begin
        if (WAY_W'(w) == lru_way) begin
          age_d[lru_set][w] = '0;
        end else if (age_q[lru_set][w] < lru_old) begin
          age_d[lru_set][w] = age_q[lru_set][w] + WAY_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      age_q      <= '{default: '0};
      victim_q   <= '0;
      req_set_q  <= '0;
      req_tag_q  <= '0;
      mem_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      age_q      <= age_d;
      victim_q   <= victim_d;
      req_set_q  <= req_set_d;
      req_tag_q  <= req_tag_d;
      mem_addr_q <= mem_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Tag/data storage and the fill buffer carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    fill_q <= fill_d;
  end

  assign bus.miss        = req & ~((state_q == IDLE) & hit_any);
  assign bus.rd_data     = rd_data_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd_req  = (state_q == SWAP_IN);
  assign bus.mem_wr_req  = (state_q == SWAP_OUT);
  assign bus.mem_wr_line = data_q[req_set_q][victim_q];
endmodule

// File: tb/tb_dcache_lru.sv
// tb_dcache_lru: self-checking bench for dcache_lru. The bench plays CPU and
// memory; a recency-list model of the cache plus a backing-store array
// predicts hits, victims, writebacks and load data.
module tb_dcache_lru;
  localparam int NW = 8, NS = 8, NWAY = 4, LB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_lru_if #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3), .TAG_ADDR_LEN(10)) bus ();

  dcache_lru #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3), .TAG_ADDR_LEN(10), .WAY_CNT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-set resident lines and a recency list (MRU first).
  bit            m_valid [NS][NWAY];
  bit            m_dirty [NS][NWAY];
  logic [9:0]    m_tag   [NS][NWAY];
  logic [LB-1:0] m_line  [NS][NWAY];
  int            m_ord   [NS][NWAY];
  int            m_cnt   [NS];
  logic [31:0]   m_rd;
  logic [LB-1:0] backing [logic [12:0]];

  task automatic chk(input string nm, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [LB-1:0] fetch(input logic [12:0] la);
    logic [LB-1:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < NW; w++) l[w*32 +: 32] = {la, 3'(w), 16'h5A5A};
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_cnt[s] = 0;
      for (int w = 0; w < NWAY; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_rd = '0;
  endfunction

  function automatic int find(input int s, input logic [9:0] t);
    for (int w = 0; w < NWAY; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int victim(input int s);
    for (int w = 0; w < NWAY; w++) if (!m_valid[s][w]) return w;
    return m_ord[s][m_cnt[s]-1];
  endfunction

  function automatic void touch(input int s, input int way);
    int p;
    p = m_cnt[s];
    for (int i = 0; i < m_cnt[s]; i++) if (m_ord[s][i] == way) p = i;
    if (p == m_cnt[s]) m_cnt[s]++;
    for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
    m_ord[s][0] = way;
  endfunction

  function automatic void install(input int s, input int v, input logic [9:0] t);
    m_valid[s][v] = 1'b1;
    m_dirty[s][v] = 1'b0;
    m_tag[s][v]   = t;
    m_line[s][v]  = fetch({t, 3'(s)});
    touch(s, v);
  endfunction

  // One CPU access, started and ended at a negedge, with the bench acting as
  // memory for any miss. dly = idle cycles before each mem_gnt.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int dly, output bit was_miss, output bit wb,
                        output logic [12:0] wb_addr, output logic [LB-1:0] wb_line,
                        output logic [31:0] rdat);
    int s, w, way, v;
    logic [9:0]  t;
    logic [12:0] la;
    w  = int'(a[4:2]);
    s  = int'(a[7:5]);
    t  = a[17:8];
    la = a[17:5];
    way = find(s, t);
    wb = 1'b0;
    wb_addr = '0;
    wb_line = '0;
    bus.addr = a; bus.rd_req = rd; bus.wr_req = wr; bus.wr_data = wd;
    #1;
    was_miss = bus.miss;
    chk("miss_first", bus.miss, (way < 0));
    if (way < 0) begin
      v = victim(s);
      @(posedge clk); @(negedge clk);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        chk("wb_req", bus.mem_wr_req, 1);
        chk("wb_no_rd", bus.mem_rd_req, 0);
        chk("wb_addr", bus.mem_addr, {m_tag[s][v], 3'(s)});
        chk("wb_line", bus.mem_wr_line, m_line[s][v]);
        wb = 1'b1; wb_addr = bus.mem_addr; wb_line = bus.mem_wr_line;
        repeat (dly) begin
          @(posedge clk); @(negedge clk);
          chk("wb_hold", bus.mem_wr_req, 1);
        end
        bus.mem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.mem_gnt = 1'b0;
        backing[{m_tag[s][v], 3'(s)}] = m_line[s][v];
      end
      chk("fill_req", bus.mem_rd_req, 1);
      chk("fill_no_wr", bus.mem_wr_req, 0);
      chk("fill_addr", bus.mem_addr, la);
      repeat (dly) begin
        @(posedge clk); @(negedge clk);
        chk("fill_hold", bus.mem_rd_req, 1);
      end
      bus.mem_rd_line = fetch(la);
      bus.mem_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.mem_gnt = 1'b0;
      #1;
      chk("swap_in_ok_miss", bus.miss, 1);
      chk("swap_in_ok_no_rd", bus.mem_rd_req, 0);
      @(posedge clk); @(negedge clk);
      install(s, v, t);
      way = v;
      #1;
      chk("hit_after_fill", bus.miss, 0);
    end
    touch(s, way);
    if (wr) begin
      m_line[s][way][w*32 +: 32] = wd;
      m_dirty[s][way] = 1'b1;
    end else begin
      m_rd = m_line[s][way][w*32 +: 32];
    end
    @(posedge clk); @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    #1;
    chk("rd_data", bus.rd_data, m_rd);
    rdat = bus.rd_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_miss;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t          vt [7];
    bit            ms, wb;
    logic [12:0]   wa;
    logic [LB-1:0] wl, pre;
    logic [31:0]   rd, a;
    int            v, op;

    vt[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'hAAAA0000};
    vt[1] = '{1'b0, 1'b1, 32'h104, 32'h12345678, 1'b0, 32'hAAAA0000};
    vt[2] = '{1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 32'h12345678};
    vt[3] = '{1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 1'b0, 32'h12345678};
    vt[4] = '{1'b1, 1'b0, 32'h108, 32'h0,        1'b0, 32'hCAFEF00D};
    vt[5] = '{1'b1, 1'b0, 32'h11C, 32'h0,        1'b0, 32'hAAAA0007};
    vt[6] = '{1'b1, 1'b0, 32'h120, 32'h0,        1'b1, 32'h00485A5A};

    for (int w = 0; w < NW; w++) pre[w*32 +: 32] = 32'hAAAA0000 + 32'(w);
    backing[13'h8] = pre;

    bus.addr = '0; bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.wr_data = '0;
    bus.mem_rd_line = '0; bus.mem_gnt = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    chk("rst_rd_req", bus.mem_rd_req, 0);
    chk("rst_wr_req", bus.mem_wr_req, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 13'h0);
    chk("idle_no_miss", bus.miss, 0);

    // Directed table: cold fill, write/read hits, read+write collision
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, i % 3, ms, wb, wa, wl, rd);
      chk($sformatf("vec%0d_miss", i), ms, vt[i].exp_miss);
      chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_no_wb", i), wb, 0);
    end

    // mem_gnt while idle is ignored
    @(negedge clk);
    bus.mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("gnt_idle_rd", bus.mem_rd_req, 0);
    chk("gnt_idle_wr", bus.mem_wr_req, 0);
    access(1, 0, 32'h104, 0, 0, ms, wb, wa, wl, rd);
    chk("gnt_idle_hit", ms, 0);

    // Dirty LRU victim is written back before the refill
    do_reset();
    access(0, 1, 32'h104, 32'h12345678, 1, ms, wb, wa, wl, rd);
    access(1, 0, 32'h200, 0, 0, ms, wb, wa, wl, rd);
    access(1, 0, 32'h300, 0, 2, ms, wb, wa, wl, rd);
    access(1, 0, 32'h400, 0, 0, ms, wb, wa, wl, rd);
    access(1, 0, 32'h500, 0, 1, ms, wb, wa, wl, rd);
    chk("evict_wb", wb, 1);
    chk("evict_wb_addr", wa, 13'h8);
    chk("evict_wb_word", wl[63:32], 32'h12345678);
    access(1, 0, 32'h200, 0, 0, ms, wb, wa, wl, rd);
    chk("evict_keeps_200", ms, 0);

    // Re-reading way 0 makes way 1 the LRU
    do_reset();
    access(1, 0, 32'h100, 0, 0, ms, wb, wa, wl, rd);
    access(1, 0, 32'h200, 0, 0, ms, wb, wa, wl, rd);
    access(1, 0, 32'h300, 0, 0, ms, wb, wa, wl, rd);
    access(1, 0, 32'h400, 0, 0, ms, wb, wa, wl, rd);
    access(1, 0, 32'h100, 0, 0, ms, wb, wa, wl, rd);
    chk("reread_hit", ms, 0);
    access(1, 0, 32'h500, 0, 0, ms, wb, wa, wl, rd);
    chk("clean_victim_no_wb", wb, 0);
    access(1, 0, 32'h100, 0, 0, ms, wb, wa, wl, rd);
    chk("lru_keep_100", ms, 0);
    access(1, 0, 32'h300, 0, 0, ms, wb, wa, wl, rd);
    chk("lru_keep_300", ms, 0);
    access(1, 0, 32'h400, 0, 0, ms, wb, wa, wl, rd);
    chk("lru_keep_400", ms, 0);
    access(1, 0, 32'h200, 0, 0, ms, wb, wa, wl, rd);
    chk("lru_evicted_200", ms, 1);

    // Reset during a refill aborts it
    do_reset();
    access(1, 0, 32'h100, 0, 0, ms, wb, wa, wl, rd);
    bus.addr = 32'h200; bus.rd_req = 1'b1;
    #1;
    chk("abort_miss", bus.miss, 1);
    @(posedge clk); @(negedge clk);
    chk("abort_fill_req", bus.mem_rd_req, 1);
    rst = 1'b1;
    #1;
    chk("abort_rd_drop", bus.mem_rd_req, 0);
    chk("abort_wr_low", bus.mem_wr_req, 0);
    chk("abort_mem_addr", bus.mem_addr, 13'h0);
    chk("abort_rd_data", bus.rd_data, 32'h0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    rst = 1'b0;
    model_reset();
    access(1, 0, 32'h100, 0, 0, ms, wb, wa, wl, rd);
    chk("abort_lost_line", ms, 1);

    // Store dropped mid-miss: refill completes, store is not applied
    @(negedge clk);
    v = victim(0);
    bus.addr = 32'h704; bus.wr_req = 1'b1; bus.wr_data = 32'hDEADBEEF;
    #1;
    chk("drop_miss", bus.miss, 1);
    @(posedge clk); @(negedge clk);
    chk("drop_fill_req", bus.mem_rd_req, 1);
    chk("drop_fill_addr", bus.mem_addr, 13'h38);
    bus.wr_req = 1'b0; bus.addr = 32'h900;
    bus.mem_rd_line = fetch(13'h38); bus.mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1;
    chk("drop_no_miss", bus.miss, 0);
    chk("drop_rd_low", bus.mem_rd_req, 0);
    @(posedge clk); @(negedge clk);
    install(0, v, 10'h7);
    access(1, 0, 32'h704, 0, 0, ms, wb, wa, wl, rd);
    chk("drop_installed", ms, 0);
    chk("drop_no_store", rd, {13'h38, 3'd1, 16'h5A5A});

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 2));
      a = $urandom();
      a[17:8] = 10'($urandom_range(0, 5));
      a[7:5]  = 3'($urandom_range(0, 1));
      access(op != 1, op != 0, a, $urandom(), int'($urandom_range(0, 3)), ms, wb, wa, wl, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
